bus_burst_slave: RTL and testbench

- Burst-capable bus responder (target) for the shared address/data bus used by the DMA controller and the other bus masters.
- Decodes transactions that fall in its address window and serves single and burst reads and writes from a local word-addressed SRAM.
- Signals completion with endTransactionOut and signals illegal accesses with busErrorOut.
- Gives the team a self-contained target for exercising DMA read and write bursts without the SDRAM controller.

---
 rtl/bus_slave_pkg.sv | 21 ++
 rtl/bus_slave_ram.sv | 33 +++
 rtl/bus_burst_slave.sv | 159 +++++++++++++++
 tb/tb_bus_burst_slave.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_slave_pkg.sv
// rtl/bus_slave_pkg.sv - shared FSM states, beat geometry and window decode helper for bus_burst_slave
package bus_slave_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_DECODE = 4'd1,
        S_READ   = 4'd2,
        S_WRITE  = 4'd3,
        S_END    = 4'd4,
        S_ERROR  = 4'd5
    } state_t;

    localparam int BEAT_BYTES = 4;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

    // Tag = byte address bits above the window; equal tags mean same window.
    function automatic logic [31:0] window_tag(input logic [31:0] addr, input int unsigned addr_width);
        return addr >> (addr_width + BEAT_SHIFT);
    endfunction

endpackage

// File: rtl/bus_slave_ram.sv
// rtl/bus_slave_ram.sv - single-port 32-bit SRAM, per-byte write enables, 1-cycle registered read
module bus_slave_ram #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_re,
    input  logic [3:0]            i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    // Read register returns zero on idle cycles so it can feed the shared bus directly.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rdata <= '0;
        end else begin
            o_rdata <= i_re ? r_mem[i_addr] : '0;
        end
    end

endmodule

// File: rtl/bus_burst_slave.sv
// rtl/bus_burst_slave.sv - burst bus target serving a local SRAM window
// Optional beat-stall insertion under BUS_SLAVE_WAIT_EN.
module bus_burst_slave
    import bus_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
    parameter int          ADDR_WIDTH   = 9
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        beginTransactionIn,
    input  logic [31:0] addressDataIn,
    input  logic        readNotWriteIn,
    input  logic [7:0]  burstSizeIn,
    input  logic [3:0]  byteEnablesIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    output logic [31:0] addressDataOut,
    output logic        dataValidOut,
    output logic        endTransactionOut,
    output logic        busErrorOut,
    output logic        busyOut
);

    state_t                r_state, w_next;
    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_cnt;
    logic                  r_rnw, r_err;
    logic [3:0]            r_be;
    logic                  r_dv, r_end, r_berr;
    logic                  w_hit, w_err_d, w_re, w_we, w_rd_hold, w_wr_hold;
    logic [ADDR_WIDTH:0]   w_sum;
    logic [3:0]            w_ram_we;

    // Reset asserts immediately but releases two clocks later, clean of the edge.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_hit   = beginTransactionIn &&
                     (window_tag(addressDataIn, ADDR_WIDTH) == window_tag(BASE_ADDRESS, ADDR_WIDTH));
    assign w_sum   = {1'b0, addressDataIn[ADDR_WIDTH+BEAT_SHIFT-1:BEAT_SHIFT]} + (ADDR_WIDTH+1)'(burstSizeIn);
    assign w_err_d = (addressDataIn[BEAT_SHIFT-1:0] != '0) || w_sum[ADDR_WIDTH];

    always_comb begin
        w_next = r_state;
        w_re   = 1'b0;
        w_we   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hit) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (r_err) begin
                    w_next = S_ERROR;
                end else if (r_rnw) begin
                    w_next = S_READ;
                    w_re   = 1'b1;
                end else begin
                    w_next = S_WRITE;
                end
            end
            S_READ: begin
                // r_cnt counts beats still to issue; the DECODE issue is beat one.
                if (endTransactionIn)   w_next = S_IDLE;
                else if (r_cnt == 8'd0) w_next = S_END;
                else if (!w_rd_hold)    w_re   = 1'b1;
            end
            S_WRITE: begin
                w_we = dataValidIn && !w_wr_hold;
                if (endTransactionIn)           w_next = S_IDLE;
                else if (w_we && r_cnt == 8'd0) w_next = S_END;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_rnw   <= 1'b0;
            r_err   <= 1'b0;
            r_be    <= '0;
            r_dv    <= 1'b0;
            r_end   <= 1'b0;
            r_berr  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_dv    <= w_re;
            r_end   <= (w_next == S_END) || (w_next == S_ERROR);
            r_berr  <= (w_next == S_ERROR);
            if (r_state == S_IDLE && w_hit) begin
                r_addr <= addressDataIn[ADDR_WIDTH+BEAT_SHIFT-1:BEAT_SHIFT];
                r_cnt  <= burstSizeIn;
                r_rnw  <= readNotWriteIn;
                r_be   <= byteEnablesIn;
                r_err  <= w_err_d;
            end else begin
                if (w_re || w_we) r_addr <= r_addr + ADDR_WIDTH'(1);
                if ((w_re && r_state == S_READ) || w_we) r_cnt <= r_cnt - 8'd1;
            end
        end
    end

`ifdef BUS_SLAVE_WAIT_EN
    logic [1:0] r_nb;
    logic       r_rd4, r_busy;

    // r_rd4 marks the cycle after a 4th read issue: no issue there, so the bubble lands after beat 4.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_nb   <= '0;
            r_rd4  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            if (r_state == S_IDLE)  r_nb <= '0;
            else if (w_re || w_we)  r_nb <= r_nb + 2'd1;
            r_rd4  <= w_re && (r_nb == 2'd3);
            r_busy <= !endTransactionIn &&
                      ((r_rd4 && r_state == S_READ) || (w_we && r_nb == 2'd3));
        end
    end

    assign w_rd_hold = r_rd4;
    assign w_wr_hold = r_busy;
    assign busyOut   = r_busy;
`else
    assign w_rd_hold = 1'b0;
    assign w_wr_hold = 1'b0;
    assign busyOut   = 1'b0;
`endif

    assign w_ram_we          = w_we ? r_be : 4'b0000;
    assign dataValidOut      = r_dv;
    assign endTransactionOut = r_end;
    assign busErrorOut       = r_berr;

    bus_slave_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .i_clk   (clock),
        .i_rst_n (w_rst_n),
        .i_re    (w_re),
        .i_we    (w_ram_we),
        .i_addr  (r_addr),
        .i_wdata (addressDataIn),
        .o_rdata (addressDataOut)
    );

endmodule

// File: tb/tb_bus_burst_slave.sv
// tb/tb_bus_burst_slave.sv - randomized scoreboard bench for bus_burst_slave
module tb_bus_burst_slave;

    localparam logic [31:0] BASE  = 32'h5000_0000;
    localparam int          WORDS = 512;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        beginTransactionIn = 1'b0;
    logic [31:0] addressDataIn = '0;
    logic        readNotWriteIn = 1'b0;
    logic [7:0]  burstSizeIn = '0;
    logic [3:0]  byteEnablesIn = '0;
    logic        dataValidIn = 1'b0;
    logic        endTransactionIn = 1'b0;
    logic [31:0] addressDataOut;
    logic        dataValidOut, endTransactionOut, busErrorOut, busyOut;

    bus_burst_slave #(.BASE_ADDRESS(BASE), .ADDR_WIDTH(9)) dut (
        .clock(clock), .resetN(resetN), .beginTransactionIn(beginTransactionIn),
        .addressDataIn(addressDataIn), .readNotWriteIn(readNotWriteIn), .burstSizeIn(burstSizeIn),
        .byteEnablesIn(byteEnablesIn), .dataValidIn(dataValidIn), .endTransactionIn(endTransactionIn),
        .addressDataOut(addressDataOut), .dataValidOut(dataValidOut), .endTransactionOut(endTransactionOut),
        .busErrorOut(busErrorOut), .busyOut(busyOut)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { logic [63:0] v; int c; } exp_t;
    exp_t        sb[$];
    logic [31:0] mem_m [WORDS];
    logic [31:0] wq[$];
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic logic [63:0] out_vec();
        return {28'd0, dataValidOut, endTransactionOut, busErrorOut, busyOut, addressDataOut};
    endfunction
    function automatic logic [63:0] v_data(input logic [31:0] d);
        return {28'd0, 4'b1000, d};
    endfunction
    localparam logic [63:0] V_END = {28'd0, 4'b0100, 32'd0};
    localparam logic [63:0] V_ERR = {28'd0, 4'b0110, 32'd0};

    function automatic void push_exp(input logic [63:0] v, input int c);
        exp_t e;
        e.v = v;
        e.c = c;
        sb.push_back(e);
    endfunction

    function automatic bit is_err(input logic [31:0] a, input int burst);
        return (a[1:0] != 2'b00) || (int'((a - BASE) >> 2) + burst >= WORDS);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every response beat the DUT presents must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (resetN) begin
                if (dataValidOut || endTransactionOut || busErrorOut) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", out_vec(), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("resp_value", out_vec(), e.v);
                        check("resp_cycle", 64'(cyc), 64'(e.c));
                    end
                end else begin
                    check("bus_idle_zero", 64'(addressDataOut), 64'd0);
                end
`ifndef BUS_SLAVE_WAIT_EN
                check("busy_low", 64'(busyOut), 64'd0);
`endif
            end
        end
    end

    task automatic xact(input logic [31:0] addr, input bit rnw, input int burst,
                        input logic [3:0] be, input int abort_beat, input bit gaps);
        int b, w, n;
        logic [31:0] d, mask;
        beginTransactionIn = 1'b1;
        addressDataIn      = addr;
        readNotWriteIn     = rnw;
        burstSizeIn        = 8'(burst);
        byteEnablesIn      = be;
        b = cyc;
        w = int'((addr - BASE) >> 2);
        step();
        beginTransactionIn = 1'b0;
        addressDataIn      = $urandom;
        dataValidIn        = !rnw;
        if (is_err(addr, burst)) begin
            push_exp(V_ERR, b + 2);
            dataValidIn = 1'b0;
            step();
            step();
            return;
        end
        if (rnw) begin
            n = (abort_beat > 0) ? abort_beat : burst + 1;
            for (int i = 0; i < n; i++) push_exp(v_data(mem_m[w + i]), b + 2 + i);
            if (abort_beat == 0) push_exp(V_END, b + 3 + burst);
            if (abort_beat > 0) begin
                while (cyc < b + 1 + abort_beat) step();
                endTransactionIn = 1'b1;
                step();
                endTransactionIn = 1'b0;
            end else begin
                step();
                beginTransactionIn = 1'b1;
                addressDataIn      = BASE + 32'($urandom_range(0, WORDS - 1) << 2);
                readNotWriteIn     = 1'b0;
                burstSizeIn        = 8'($urandom_range(0, 3));
                step();
                beginTransactionIn = 1'b0;
                while (cyc < b + 4 + burst) step();
            end
        end else begin
            step();
            for (int i = 0; i <= burst; i++) begin
                if (gaps) begin
                    repeat ($urandom_range(0, 2)) begin
                        dataValidIn      = 1'b0;
                        endTransactionIn = 1'b0;
                        step();
                    end
                end
                d = (wq.size() != 0) ? wq.pop_front() : $urandom;
                dataValidIn      = 1'b1;
                addressDataIn    = d;
                endTransactionIn = (i + 1 == abort_beat);
                for (int k = 0; k < 4; k++) mask[8*k +: 8] = {8{be[k]}};
                mem_m[w + i] = (mem_m[w + i] & ~mask) | (d & mask);
                step();
                if (i + 1 == abort_beat) break;
            end
            dataValidIn      = 1'b0;
            endTransactionIn = 1'b0;
            if (abort_beat == 0) begin
                push_exp(V_END, cyc);
                step();
            end
        end
    endtask

    task automatic hit_reset(input string name);
        resetN = 1'b0;
        #1;
        check(name, out_vec(), 64'd0);
        beginTransactionIn = 1'b0;
        dataValidIn        = 1'b0;
        endTransactionIn   = 1'b0;
        step();
        step();
        resetN = 1'b1;
        repeat (3) step();
    endtask

    task automatic fill_mem();
        xact(BASE, 1'b0, 255, 4'hF, 0, 1'b0);
        xact(BASE + 32'h400, 1'b0, 255, 4'hF, 0, 1'b0);
    endtask

    initial begin
        int b, k, burst, w, ab;
        logic [31:0] a;
        bit rnw;
        step();
        step();
        check("reset_state", out_vec(), 64'd0);
        resetN = 1'b1;
        repeat (3) step();
        fill_mem();

        wq.push_back(32'h1111_1111); wq.push_back(32'h2222_2222);
        wq.push_back(32'h3333_3333); wq.push_back(32'h4444_4444);
        for (int i = 0; i < 4; i++) xact(BASE + 32'(4 * i), 1'b0, 0, 4'hF, 0, 1'b0);
        xact(BASE, 1'b1, 3, 4'hF, 0, 1'b0);

        wq.push_back(32'hFFFF_FFFF);
        xact(BASE + 32'h10, 1'b0, 0, 4'hF, 0, 1'b0);
        wq.push_back(32'hAABB_CCDD);
        xact(BASE + 32'h10, 1'b0, 0, 4'b0101, 0, 1'b0);
        xact(BASE + 32'h10, 1'b1, 0, 4'hF, 0, 1'b0);

        xact(BASE + 32'h2, 1'b1, 0, 4'hF, 0, 1'b0);
        xact(BASE + 32'h7FC, 1'b0, 1, 4'hF, 0, 1'b0);
        xact(BASE + 32'h1, 1'b0, 2, 4'hF, 0, 1'b0);
        xact(BASE + 32'h404, 1'b1, 255, 4'hF, 0, 1'b0);
        xact(BASE, 1'b1, 3, 4'hF, 0, 1'b0);
        xact(BASE + 32'h7F8, 1'b1, 1, 4'hF, 0, 1'b0);
        xact(BASE + 32'h400, 1'b1, 255, 4'hF, 0, 1'b0);
        xact(BASE + 32'h7FC, 1'b1, 0, 4'hF, 0, 1'b0);

        beginTransactionIn = 1'b1;
        addressDataIn      = 32'h6000_0000;
        readNotWriteIn     = 1'b1;
        burstSizeIn        = 8'd3;
        step();
        beginTransactionIn = 1'b0;
        repeat (6) begin
            step();
            check("ignored_quiet", out_vec(), 64'd0);
        end

        xact(BASE + 32'h40, 1'b1, 7, 4'hF, 3, 1'b0);
        xact(BASE + 32'h80, 1'b0, 5, 4'hF, 2, 1'b1);
        xact(BASE + 32'h80, 1'b1, 5, 4'hF, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            rnw   = 1'($urandom_range(0, 1));
            burst = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
            w     = $urandom_range(0, WORDS - 1);
            a     = BASE + 32'(w << 2) + (($urandom_range(0, 15) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            ab    = ($urandom_range(0, 5) == 0) ? $urandom_range(1, burst + 1) : 0;
            xact(a, rnw, burst, 4'($urandom_range(1, 15)), ab, 1'b1);
        end

        beginTransactionIn = 1'b1;
        addressDataIn      = BASE;
        readNotWriteIn     = 1'b1;
        burstSizeIn        = 8'd7;
        b = cyc;
        push_exp(v_data(mem_m[0]), b + 2);
        step();
        beginTransactionIn = 1'b0;
        step();
        step();
        check("read_live_before_reset", 64'(dataValidOut), 64'd1);
        #1;
        hit_reset("reset_mid_read_zero");
        check("sb_after_read_reset", 64'(sb.size()), 64'd0);

        beginTransactionIn = 1'b1;
        addressDataIn      = BASE + 32'h100;
        readNotWriteIn     = 1'b0;
        burstSizeIn        = 8'd3;
        byteEnablesIn      = 4'hF;
        step();
        beginTransactionIn = 1'b0;
        step();
        dataValidIn   = 1'b1;
        addressDataIn = $urandom;
        step();
        addressDataIn = $urandom;
        #2;
        hit_reset("reset_mid_write_zero");

        fill_mem();
        xact(BASE + 32'h100, 1'b1, 3, 4'hF, 0, 1'b0);
        xact(BASE + 32'h100, 1'b0, 3, 4'hF, 0, 1'b1);
        xact(BASE + 32'h100, 1'b1, 3, 4'hF, 0, 1'b0);

        k = 0;
        while (sb.size() != 0 && k < 100) begin
            step();
            k++;
        end
        repeat (4) step();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog_timeout actual=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
